// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle of the stopwatch scan controller: time/blink inputs in,
// multiplexed segment/anode drive and frame strobe out.
interface seg_scan_ctrl_if;
   logic [5:0] min;
   logic [5:0] sec;
   logic       blink_min;
   logic       blink_sec;
   logic [6:0] seg;
   logic [3:0] an;
   logic       frame_done;

   modport master (
      output min, sec, blink_min, blink_sec,
      input  seg, an, frame_done
   );

   modport slave (
      input  min, sec, blink_min, blink_sec,
      output seg, an, frame_done
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit mm:ss scan scheduler with guard gaps, field blinking and per-frame snapshot.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank digit 3 when minutes tens is zero).
module seg_scan_ctrl #(
   parameter int CLK_HZ    = 100_000_000,
   parameter int SCAN_HZ   = 1000,
   parameter int BLINK_HZ  = 2,
   parameter int GUARD_CYC = 4
) (
   input  logic           clk,
   input  logic           reset_n,
   seg_scan_ctrl_if.slave bus
);

   localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
   localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
   localparam int SCAN_W    = $clog2(SCAN_DIV + 1);
   localparam int BLINK_W   = $clog2(BLINK_DIV + 1);

   logic [SCAN_W-1:0]  slot_cnt;
   logic [1:0]         idx;
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_ph;
   logic [5:0]         min_sh;
   logic [5:0]         sec_sh;

   logic               slot_end;
   logic [7:0]         min_bcd;
   logic [7:0]         sec_bcd;
   logic [3:0]         digit;
   logic [3:0]         an_next;

   logic [6:0]         seg_p1;
   logic [3:0]         an_p1;
   logic               frame_done_p1;

   function automatic logic [5:0] sat59(input logic [5:0] v);
      return (v > 6'd59) ? 6'd59 : v;
   endfunction

   // Tens/ones by compare-and-subtract; input is already limited to 0..59.
   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      logic [5:0] r;
      logic [3:0] t;
      r = v;
      if (r >= 6'd50) begin
         t = 4'd5; r = r - 6'd50;
      end else if (r >= 6'd40) begin
         t = 4'd4; r = r - 6'd40;
      end else if (r >= 6'd30) begin
         t = 4'd3; r = r - 6'd30;
      end else if (r >= 6'd20) begin
         t = 4'd2; r = r - 6'd20;
      end else if (r >= 6'd10) begin
         t = 4'd1; r = r - 6'd10;
      end else begin
         t = 4'd0;
      end
      return {t, r[3:0]};
   endfunction

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] c;
      case (d)
         4'd0:    c = 7'h40;
         4'd1:    c = 7'h79;
         4'd2:    c = 7'h24;
         4'd3:    c = 7'h30;
         4'd4:    c = 7'h19;
         4'd5:    c = 7'h12;
         4'd6:    c = 7'h02;
         4'd7:    c = 7'h78;
         4'd8:    c = 7'h00;
         4'd9:    c = 7'h10;
         default: c = 7'h7F;
      endcase
      return c;
   endfunction

   assign slot_end = (slot_cnt == SCAN_W'(SCAN_DIV - 1));
   assign min_bcd  = to_bcd(sat59(min_sh));
   assign sec_bcd  = to_bcd(sat59(sec_sh));

   always_comb begin
      digit = 4'd0;
      case (idx)
         2'd3:    digit = min_bcd[7:4];
         2'd2:    digit = min_bcd[3:0];
         2'd1:    digit = sec_bcd[7:4];
         default: digit = sec_bcd[3:0];
      endcase
   end

   // Anode gating: guard gap first, then blink masking of whole fields.
   always_comb begin
      an_next = 4'hF;
      if (slot_cnt >= SCAN_W'(GUARD_CYC))
         an_next[idx] = 1'b0;
      if (blink_ph) begin
         if (bus.blink_min) an_next[3:2] = 2'b11;
         if (bus.blink_sec) an_next[1:0] = 2'b11;
      end
`ifdef LEADING_ZERO_BLANK_EN
      if (min_bcd[7:4] == 4'd0)
         an_next[3] = 1'b1;
`endif
   end

   // Stage p0 -> p1: scan/blink state and snapshot feed the registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot_cnt      <= '0;
         idx           <= 2'd3;
         blink_cnt     <= '0;
         blink_ph      <= 1'b0;
         min_sh        <= 6'd0;
         sec_sh        <= 6'd0;
         seg_p1        <= 7'h7F;
         an_p1         <= 4'hF;
         frame_done_p1 <= 1'b0;
      end else begin
         slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
         if (slot_end)
            idx <= idx - 2'd1;
         if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
         if (slot_end && idx == 2'd0) begin
            min_sh <= bus.min;
            sec_sh <= bus.sec;
         end
         seg_p1        <= seg_code(digit);
         an_p1         <= an_next;
         frame_done_p1 <= slot_end && (idx == 2'd0);
      end
   end

   assign bus.seg        = seg_p1;
   assign bus.an         = an_p1;
   assign bus.frame_done = frame_done_p1;

endmodule
